data_format_in: RTL and testbench
=================================

// Module: data_format_in
// PURPOSE
//  Width packer feeding the DDR2 write path: gathers DI_WIDTH-bit user words into
//  DO_WIDTH-bit words for the memory-side interface and the data_format_out unpacker.
//  Ready/valid on both sides, single-entry output register, explicit flush that
//  emits a zero-padded partial word with a per-slot valid mask.
// PARAMETERS
//  DI_WIDTH  32  input word width; DO_WIDTH must be an integer multiple of it
//  DO_WIDTH  64  packed output width
//  RATIO     localparam = DO_WIDTH/DI_WIDTH (>=2); CW = clog2(RATIO) slot-counter width
// PORTS
//  clk        in   1         single clock, all logic rising-edge
//  reset      in   1         asynchronous, active-high; clears all state
//  data_in    in   DI_WIDTH  input word
//  din_vd     in   1         data_in valid
//  din_rdy    out  1         block accepts data_in/flush this cycle
//  flush      in   1         close current partial word; qualified by din_rdy
//  data_out   out  DO_WIDTH  packed word; slot 0 in bits [DI_WIDTH-1:0]
//  dout_mask  out  RATIO     bit k = slot k holds real data
//  dout_vd    out  1         data_out/dout_mask valid
//  dout_rdy   in   1         downstream accepts data_out
// BEHAVIOUR
//  - Reset: data_out=0, dout_mask=0, dout_vd=0, slot counter=0, accumulator=0;
//    din_rdy=0 while reset high.
//  - din_rdy = !dout_vd || dout_rdy (combinational from dout_rdy; no other path).
//  - Accept: din_vd && din_rdy. Word written to accumulator slot cnt; cnt+1.
//  - Word completes when accepted with cnt==RATIO-1: on that edge output register
//    loads {data_in, acc[slots 0..RATIO-2]}, dout_mask=all-ones, dout_vd=1, cnt=0.
//    Latency: completing word at edge N -> dout_vd high from edge N.
//  - Output handshake: dout_vd && dout_rdy retires word; dout_vd drops next edge unless
//    a new word loads on the same edge (back-to-back: one packed word per RATIO accepts,
//    no bubbles with dout_rdy held high).
//  - Output register holds data_out/dout_mask stable while dout_vd && !dout_rdy.
//  - flush && din_rdy: if cnt!=0 (after counting any same-cycle accepted word), emit
//    partial word: unfilled slots zero, dout_mask bit k=1 for k<filled count, cnt=0.
//    flush with din_vd same cycle: data_in included first, then flush.
//    flush when that data_in completes a full word: full word only, no extra empty word.
//    flush with cnt==0 and no data: no-op, no output.
//  - flush or din_vd while din_rdy=0: ignored; upstream holds both until din_rdy.
//  - Accumulator slots not yet written in the current word read as zero.
//  - Reset mid-word or mid-stall: partial data and pending output discarded, no emit.
//  - Non-integer ratio or RATIO<2: elaboration-time error ($error / invalid generate).
// STRUCTURE
//  - Shared include ddr2_fmt_defs.vh: default DI/DO widths, RATIO and CW calc macros,
//    shared with data_format_out so both sides agree on slot ordering.
//  - One sub-module: data_fmt_hold_reg (single-entry valid/ready register carrying
//    data+mask); packer FSM is implicit in cnt (EMPTY: cnt==0, FILLING: cnt>0).
// TESTING
//  1 Reset: assert reset mid-stream -> dout_vd=0, data_out=0, din_rdy=0; after release
//    first accepted word lands in slot 0.
//  2 Stream 0x11111111,0x22222222, dout_rdy=1 -> data_out=0x22222222_11111111, mask=2'b11,
//    dout_vd on edge of 2nd accept; 8 words -> 4 packed words, no gaps.
//  3 Backpressure: dout_rdy=0 after first packed word -> din_rdy=0, data_out stable for
//    10 cycles; release -> next word packs correctly, none lost or duplicated.
//  4 Flush after one word 0xAAAA5555 -> data_out=0x00000000_AAAA5555, mask=2'b01; flush
//    with cnt==0 -> no dout_vd.
//  5 flush with din_vd on 2nd word -> one full word mask=2'b11, no trailing empty word.
//  6 RATIO=4 (DO_WIDTH=128): 3 words + flush -> mask=4'b0111, top slot zero.

Source files
------------

// File: rtl/data_format_in_pkg.sv
// Shared widths and slot math for the DDR2 write-path packer.
// Both packer and unpacker use these so slot ordering agrees.
package data_format_in_pkg;

    localparam int DI_W_DEF = 32;
    localparam int DO_W_DEF = 64;

    function automatic int ratio_f(int di_w, int do_w);
        return do_w / di_w;
    endfunction

    function automatic int cw_f(int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/data_format_in_if.sv
// Ready/valid bundle between user side, packer and memory side.
interface data_format_in_if
    import data_format_in_pkg::*;
#(
    parameter int DI_WIDTH = DI_W_DEF,
    parameter int DO_WIDTH = DO_W_DEF
);
    localparam int RATIO = ratio_f(DI_WIDTH, DO_WIDTH);

    logic [DI_WIDTH-1:0] data_in;
    logic                din_vd;
    logic                din_rdy;
    logic                flush;
    logic [DO_WIDTH-1:0] data_out;
    logic [RATIO-1:0]    dout_mask;
    logic                dout_vd;
    logic                dout_rdy;

    modport master (
        output data_in, din_vd, flush, dout_rdy,
        input  din_rdy, data_out, dout_mask, dout_vd
    );

    modport slave (
        input  data_in, din_vd, flush, dout_rdy,
        output din_rdy, data_out, dout_mask, dout_vd
    );

endinterface

// File: rtl/data_format_in_hold_reg.sv
// Single-entry valid/ready output register carrying packed data and slot mask.
module data_fmt_hold_reg #(
    parameter int DW = 64,
    parameter int MW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [MW-1:0] mask_i,
    input  logic          rdy_i,
    output logic          vd_o,
    output logic [DW-1:0] data_o,
    output logic [MW-1:0] mask_o
);

    logic          vd_q;
    logic [DW-1:0] data_q;
    logic [MW-1:0] mask_q;

    // A load always wins: the packer only loads when the entry is free or retiring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vd_q   <= 1'b0;
            data_q <= '0;
            mask_q <= '0;
        end else if (load_i) begin
            vd_q   <= 1'b1;
            data_q <= data_i;
            mask_q <= mask_i;
        end else if (vd_q && rdy_i) begin
            vd_q   <= 1'b0;
        end
    end

    assign vd_o   = vd_q;
    assign data_o = data_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/data_format_in.sv
// Packs DI_WIDTH user words into DO_WIDTH memory words, slot 0 in the LSBs,
// with flush emitting a zero-padded partial word and per-slot valid mask.
module data_format_in
    import data_format_in_pkg::*;
#(
    parameter int DI_WIDTH = DI_W_DEF,
    parameter int DO_WIDTH = DO_W_DEF
) (
    input logic             clk,
    input logic             reset,
    data_format_in_if.slave bus
);

    localparam int RATIO = ratio_f(DI_WIDTH, DO_WIDTH);
    localparam int CW    = cw_f(RATIO);

    generate
        if ((DO_WIDTH % DI_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("data_format_in: DO_WIDTH must be >=2x integer multiple of DI_WIDTH");
        end
    endgenerate

    logic [RATIO-1:0][DI_WIDTH-1:0] acc_q, acc_d, word;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [CW:0]                    fill;
    logic                           rdy, vd, accept, fl, load;
    logic [RATIO-1:0]               ld_mask;

    assign rdy         = !reset && (!vd || bus.dout_rdy);
    assign bus.din_rdy = rdy;
    assign accept      = bus.din_vd && rdy;
    assign fl          = bus.flush && rdy;

    // Cleared slots double as the zero padding for partial words.
    always_comb begin
        word = acc_q;
        if (accept) word[cnt_q] = bus.data_in;
        fill    = {1'b0, cnt_q} + {{CW{1'b0}}, accept};
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        ld_mask = '0;
        for (int k = 0; k < RATIO; k++)
            ld_mask[k] = ((CW+1)'(k) < fill);
        if (accept && cnt_q == CW'(RATIO - 1)) begin
            load  = 1'b1;
            cnt_d = '0;
            acc_d = '0;
        end else if (fl && fill != '0) begin
            load  = 1'b1;
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            acc_d = word;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    data_fmt_hold_reg #(
        .DW(DO_WIDTH),
        .MW(RATIO)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .data_i (word),
        .mask_i (ld_mask),
        .rdy_i  (bus.dout_rdy),
        .vd_o   (vd),
        .data_o (bus.data_out),
        .mask_o (bus.dout_mask)
    );

    assign bus.dout_vd = vd;

endmodule

// File: tb/tb_data_format_in.sv
// Directed bench for data_format_in at RATIO=2 and RATIO=4.
module tb_data_format_in;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_format_in_if #(.DI_WIDTH(32), .DO_WIDTH(64))  b2();
    data_format_in_if #(.DI_WIDTH(32), .DO_WIDTH(128)) b4();

    data_format_in #(.DI_WIDTH(32), .DO_WIDTH(64)) u2 (
        .clk(clk), .reset(reset), .bus(b2)
    );
    data_format_in #(.DI_WIDTH(32), .DO_WIDTH(128)) u4 (
        .clk(clk), .reset(reset), .bus(b4)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [31:0] d, input logic f);
        b2.data_in = d; b2.din_vd = 1'b1; b2.flush = f;
        step();
        b2.din_vd = 1'b0; b2.flush = 1'b0;
    endtask

    task automatic fl2();
        b2.flush = 1'b1;
        step();
        b2.flush = 1'b0;
    endtask

    task automatic push4(input logic [31:0] d);
        b4.data_in = d; b4.din_vd = 1'b1;
        step();
        b4.din_vd = 1'b0;
    endtask

    logic [31:0] w, prev;

    initial begin
        b2.data_in = '0; b2.din_vd = 1'b0; b2.flush = 1'b0; b2.dout_rdy = 1'b1;
        b4.data_in = '0; b4.din_vd = 1'b0; b4.flush = 1'b0; b4.dout_rdy = 1'b1;
        reset = 1'b1;
        step();
        step();
        chk("rst_vd",   b2.dout_vd, 0);
        chk("rst_data", b2.data_out, 0);
        chk("rst_mask", b2.dout_mask, 0);
        chk("rst_rdy",  b2.din_rdy, 0);
        chk("rst_vd4",  b4.dout_vd, 0);
        reset = 1'b0;
        #1;
        chk("rdy_after_rst", b2.din_rdy, 1);

        // basic pair and streaming
        push2(32'h11111111, 1'b0);
        chk("s1_vd", b2.dout_vd, 0);
        push2(32'h22222222, 1'b0);
        chk("s2_vd",   b2.dout_vd, 1);
        chk("s2_data", b2.data_out, 64'h22222222_11111111);
        chk("s2_mask", b2.dout_mask, 2'b11);
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            w = 32'h01010101 * (i + 1);
            push2(w, 1'b0);
            if (i % 2 == 1) begin
                chk("str_vd",   b2.dout_vd, 1);
                chk("str_data", b2.data_out, {w, prev});
            end else begin
                chk("str_gap", b2.dout_vd, 0);
            end
            prev = w;
        end

        // backpressure while holding {08.., 07..}
        b2.dout_rdy = 1'b0;
        #1;
        chk("bp_rdy", b2.din_rdy, 0);
        b2.data_in = 32'h33333333; b2.din_vd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_data", b2.data_out, 64'h08080808_07070707);
            chk("bp_vd",   b2.dout_vd, 1);
        end
        b2.dout_rdy = 1'b1;
        #1;
        chk("bp_rel_rdy", b2.din_rdy, 1);
        step();
        b2.din_vd = 1'b0;
        chk("bp_retire", b2.dout_vd, 0);
        push2(32'h44444444, 1'b0);
        chk("bp_next_vd",   b2.dout_vd, 1);
        chk("bp_next_data", b2.data_out, 64'h44444444_33333333);

        // flush of a partial word, then empty flush
        push2(32'hAAAA5555, 1'b0);
        chk("f1_vd0", b2.dout_vd, 0);
        fl2();
        chk("f1_vd",   b2.dout_vd, 1);
        chk("f1_data", b2.data_out, 64'h00000000_AAAA5555);
        chk("f1_mask", b2.dout_mask, 2'b01);
        fl2();
        chk("f0_novd", b2.dout_vd, 0);

        // flush on the completing word
        push2(32'h12345678, 1'b0);
        push2(32'h9ABCDEF0, 1'b1);
        chk("fc_vd",   b2.dout_vd, 1);
        chk("fc_data", b2.data_out, 64'h9ABCDEF0_12345678);
        chk("fc_mask", b2.dout_mask, 2'b11);
        step();
        chk("fc_noextra", b2.dout_vd, 0);
        push2(32'h0BADF00D, 1'b1);
        chk("fd_data", b2.data_out, 64'h00000000_0BADF00D);
        chk("fd_mask", b2.dout_mask, 2'b01);

        // reset mid-word
        push2(32'h55555555, 1'b0);
        push4(32'h99999999);
        reset = 1'b1;
        #1;
        chk("mr_vd",   b2.dout_vd, 0);
        chk("mr_data", b2.data_out, 0);
        chk("mr_rdy",  b2.din_rdy, 0);
        step();
        reset = 1'b0;
        push2(32'h77777777, 1'b0);
        chk("mr_noemit", b2.dout_vd, 0);
        fl2();
        chk("mr_data2", b2.data_out, 64'h00000000_77777777);
        chk("mr_mask2", b2.dout_mask, 2'b01);

        // RATIO=4
        push4(32'hA1A1A1A1);
        push4(32'hB2B2B2B2);
        push4(32'hC3C3C3C3);
        chk("r4_vd0", b4.dout_vd, 0);
        b4.flush = 1'b1;
        step();
        b4.flush = 1'b0;
        chk("r4_vd",   b4.dout_vd, 1);
        chk("r4_mask", b4.dout_mask, 4'b0111);
        chk("r4_data", b4.data_out,
            128'h00000000_C3C3C3C3_B2B2B2B2_A1A1A1A1);
        push4(32'h01);
        push4(32'h02);
        push4(32'h03);
        push4(32'h04);
        chk("r4_full_mask", b4.dout_mask, 4'b1111);
        chk("r4_full_data", b4.data_out,
            128'h00000004_00000003_00000002_00000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
